// File: rtl/seg_pkg.sv
// seg_pkg: shared state encoding and active-low hex segment table for the digit scanner
package seg_pkg;
    typedef enum logic [1:0] {IDLE, SHOW, BLANK} state_t;
    localparam logic [7:0] SEG_OFF = 8'hFF;
    // {a,b,c,d,e,f,g,dp} active-low, dp off; entry 15 is the MSB byte
    localparam logic [15:0][7:0] HEX_SEG = {
        8'h71, 8'h61, 8'h85, 8'h63, 8'hC1, 8'h11, 8'h09, 8'h01,
        8'h1F, 8'h41, 8'h49, 8'h99, 8'h0D, 8'h25, 8'h9F, 8'h03
    };
endpackage

// File: rtl/seg_hex_decoder.sv
// seg_hex_decoder: maps a hex nibble and decimal point to an active-low segment pattern
module seg_hex_decoder
    import seg_pkg::*;
(
    input  logic [3:0] value,
    input  logic       dp,
    output logic [7:0] seg
);
    assign seg = {HEX_SEG[value][7:1], ~dp};
endmodule

// File: rtl/seg_scan_scheduler.sv
// seg_scan_scheduler: scans eight digits onto the shared segment bus with frame-synchronous shadowing and blanking
module seg_scan_scheduler
    import seg_pkg::*;
#(
    parameter int NUM_DIGITS   = 8,
    parameter int DIGIT_CYCLES = 100_000,
    parameter int BLANK_CYCLES = 1_000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        global_led_en,
    input  logic [31:0] digits_in,
    input  logic [7:0]  digit_mask,
    input  logic [7:0]  dp_mask,
    input  logic        load,
    output logic [7:0]  led_en,
    output logic [7:0]  led_cx,
    output logic [2:0]  cur_digit,
    output logic        frame_done
);
    localparam int CW = $clog2(DIGIT_CYCLES);
    localparam logic [CW-1:0] SLOT_LAST = CW'(DIGIT_CYCLES - 1);
    localparam logic [CW-1:0] SHOW_LAST = CW'(DIGIT_CYCLES - BLANK_CYCLES - 1);
    localparam logic [2:0] DIG_LAST = 3'(NUM_DIGITS - 1);

    state_t state, state_n;
    logic [CW-1:0] cnt, cnt_n;
    logic [2:0] idx, idx_n;
    logic [31:0] pend_val, shad_val;
    logic [7:0] pend_mask, shad_mask, pend_dp, shad_dp;
    logic [7:0] en_d, cx_d, seg;
    logic slot_end, frame_end, frame_start;

    assign slot_end    = state != IDLE && cnt == SLOT_LAST;
    assign frame_end   = slot_end && idx == DIG_LAST;
    assign frame_start = global_led_en && (state == IDLE || frame_end);
    assign cur_digit   = idx;

    seg_hex_decoder u_dec (
        .value(shad_val[{idx, 2'b00} +: 4]),
        .dp   (shad_dp[idx]),
        .seg  (seg)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= IDLE;
            cnt        <= '0;
            idx        <= '0;
            pend_val   <= '0;
            pend_mask  <= '0;
            pend_dp    <= '0;
            shad_val   <= '0;
            shad_mask  <= '0;
            shad_dp    <= '0;
            led_en     <= SEG_OFF;
            led_cx     <= SEG_OFF;
            frame_done <= 1'b0;
        end else begin
            state      <= state_n;
            cnt        <= cnt_n;
            idx        <= idx_n;
            led_en     <= en_d;
            led_cx     <= cx_d;
            frame_done <= frame_end;
            if (load) begin
                pend_val  <= digits_in;
                pend_mask <= digit_mask;
                pend_dp   <= dp_mask;
            end
            // a load landing on the frame boundary bypasses pending so it shows this frame
            if (frame_start) begin
                shad_val  <= load ? digits_in : pend_val;
                shad_mask <= load ? digit_mask : pend_mask;
                shad_dp   <= load ? dp_mask : pend_dp;
            end
        end
    end

    always_comb begin
        state_n = !global_led_en ? IDLE :
                  state == IDLE  ? SHOW :
                  state == SHOW  ? ((cnt == SHOW_LAST && BLANK_CYCLES != 0) ? BLANK : SHOW) :
                  (slot_end ? SHOW : BLANK);
        cnt_n   = (!global_led_en || state == IDLE || slot_end) ? '0 : cnt + 1'b1;
        idx_n   = (!global_led_en || state == IDLE) ? '0 :
                  slot_end ? (idx == DIG_LAST ? '0 : idx + 1'b1) : idx;
    end

    always_comb begin
        en_d = (state == SHOW && shad_mask[idx]) ? ~(8'h01 << idx) : SEG_OFF;
        cx_d = state == SHOW ? seg : SEG_OFF;
    end
endmodule

// File: doc/seg_scan_scheduler.md
Name: seg_scan_scheduler

Overview:
- Time-multiplexes the shared 8-digit seven-segment bus (led_en / led_cx) between eight digit sources.
- Sits between the stopwatch counter datapath and the board pins. It replaces ad-hoc scanning in top.
- Frame-synchronous shadow loading prevents tearing. A blanking gap between digits suppresses ghosting.
- Honours global_led_en and per-digit enable masks.

Parameters:
- NUM_DIGITS, 8: digits scanned. Index width is 3.
- DIGIT_CYCLES, 100_000: clock cycles per digit slot (1 ms at 100 MHz). Must be at least 2.
- BLANK_CYCLES, 1_000: cycles at the end of each slot with all digits off. Must be less than DIGIT_CYCLES; 0 means no blanking.

Ports:
- clk  in  1  system clock, 100 MHz
- reset  in  1  synchronous, active-high reset
- global_led_en  in  1  display enable. 0 forces all digits off.
- digits_in  in  32  hex values; digit i occupies bits [4i+3:4i].
- digit_mask  in  8  per-digit enable; 1 = shown
- dp_mask  in  8  per-digit decimal point; 1 = lit
- load  in  1  one-cycle strobe that captures digits_in, digit_mask and dp_mask into the pending register
- led_en  out  8  digit selects, active-low, registered
- led_cx  out  8  segments, active-low, registered. Bit 7 = a … bit 1 = g, bit 0 = dp.
- cur_digit  out  3  index of the digit being scanned
- frame_done  out  1  one-cycle pulse at the end of digit 7's slot

Behaviour:
- Reset (synchronous, active-high): led_en=8'hFF, led_cx=8'hFF, cur_digit=0, frame_done=0, state=IDLE. Pending and shadow registers (values, masks, dp) are cleared to 0.
- FSM states: IDLE, SHOW, BLANK.
  - IDLE: outputs off, slot counter=0, cur_digit=0. Moves to SHOW on the first cycle with global_led_en=1. That transition is a frame start.
  - SHOW: lasts DIGIT_CYCLES-BLANK_CYCLES cycles. Drives digit cur_digit: led_en has bit cur_digit low (only if shadow digit_mask[cur_digit]=1), led_cx = decode(shadow value) with dp from the shadow dp_mask. At the last cycle it moves to BLANK, or straight to the next SHOW if BLANK_CYCLES=0.
  - BLANK: lasts BLANK_CYCLES cycles with led_en=8'hFF and led_cx=8'hFF. At the last cycle cur_digit increments, wrapping 7→0, and the FSM re-enters SHOW.
- Slot counter width is $clog2(DIGIT_CYCLES). It counts 0..DIGIT_CYCLES-1 across SHOW+BLANK and restarts at 0 on each slot.
- Outputs are registered, so the pins lag the FSM state by exactly 1 cycle.
- A masked digit keeps its full slot timing; its led_en bit simply stays 1.
- frame_done is asserted for 1 cycle on the cycle the digit-7 slot ends, i.e. the wrap to 0.
- Shadow update happens at each frame start (IDLE→SHOW, or wrap 7→0): shadow ← pending.
  - load in any cycle: pending ← inputs.
  - load coinciding with a frame start: the inputs go directly into shadow and pending.
  - Back-to-back loads: the last load wins.
- global_led_en falling in any state: next cycle state=IDLE and the outputs go off one cycle later. The partial slot is abandoned. A re-enable always restarts at digit 0 with a fresh shadow copy.
- Reset mid-frame: identical to the power-on reset values. No frame_done pulse.
- Hex decode covers 0–F (e.g. 0→a..f on, 8→all on, F→a,e,f,g on). The codebase digit set is complete; no illegal values.

Decomposition:
- Package seg_pkg holds:
  - state enum {IDLE, SHOW, BLANK}
  - SEG_OFF=8'hFF
  - 16-entry hex→segment constant table (active-low, a..g, dp=1)
- One combinational sub-module, seg_hex_decoder, maps a 4-bit value plus dp to an 8-bit active-low pattern. It is instantiated once and muxed by cur_digit.

Test Plan (DIGIT_CYCLES=10, BLANK_CYCLES=2 unless noted):
1. Reset released with global_led_en=1 and digits_in=32'h76543210 loaded during reset-release → led_en=8'hFE for 8 cycles with led_cx = decode(0), then 8'hFF for 2 cycles, then 8'hFD with decode(1). frame_done pulses exactly every 80 cycles.
2. digit_mask=8'b1010_1010 → led_en never drives bits 0, 2, 4, 6 low, and the slot cadence is unchanged (still 10 cycles per index).
3. load of 32'hFFFFFFFF mid-frame at digit 3 → digits 3–7 still show the old values. The new value first appears at digit 0 of the next frame. A load coinciding with the wrap cycle takes effect in that same frame.
4. global_led_en dropped during digit 5 SHOW → led_en=8'hFF two cycles later. Re-raised → within 2 cycles led_en=8'hFE and cur_digit=0.
5. Synchronous reset pulse of 1 cycle mid-BLANK → all outputs are 8'hFF on the next edge, cur_digit=0, and no frame_done. Scanning resumes from digit 0.
6. With BLANK_CYCLES=0 → digits are contiguous (no all-off cycle), and frame_done pulses every 80 cycles.
